// File: rtl/alu_logic_arbiter.sv
// Purpose: two-requester arbiter around a registered bitwise logic unit (OR/AND/XOR/NOR); ALU_ARB_RR_EN selects round-robin over fixed priority.
// Latency: accept in N, execute in N+1, response valid from N+2; one command in flight, peak one per 3 cycles.
// Backpressure: request ready only in IDLE; RESP holds valid and data until the owning requester's rsp ready.
module alu_logic_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             id;
    } cmd_t;

    state_t state, state_nxt;
    cmd_t   cmd, cmd_sel;
    logic   gnt_any;
    logic   gnt_id;

`ifdef ALU_ARB_RR_EN
    logic last_grant;

    // Reset value 1 makes requester 0 the winner of the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (gnt_any)
            last_grant <= gnt_id;
    end
`endif

    function automatic logic [WIDTH-1:0] logic_op(input cmd_t c);
        case (c.op)
            2'b00:   logic_op = c.a | c.b;
            2'b01:   logic_op = c.a & c.b;
            2'b10:   logic_op = c.a ^ c.b;
            default: logic_op = ~(c.a | c.b);
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        gnt_any   = 1'b0;
        gnt_id    = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    gnt_any = 1'b1;
`ifdef ALU_ARB_RR_EN
                    if (req0_valid && req1_valid)
                        gnt_id = ~last_grant;
                    else
                        gnt_id = req1_valid;
`else
                    gnt_id = ~req0_valid;
`endif
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (cmd.id ? rsp1_ready : rsp0_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_sel = gnt_id ? '{op: req1_op, a: req1_a, b: req1_b, id: 1'b1}
                         : '{op: req0_op, a: req0_a, b: req0_b, id: 1'b0};
    end

    // Grants are masked during reset so nothing is accepted into a block being cleared.
    assign req0_ready = rst_n & gnt_any & ~gnt_id;
    assign req1_ready = rst_n & gnt_any &  gnt_id;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd      <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_any)
                cmd <= cmd_sel;
            if (state == EXEC)
                rsp_data <= logic_op(cmd);
        end
    end

    assign rsp0_valid = (state == RESP) && !cmd.id;
    assign rsp1_valid = (state == RESP) &&  cmd.id;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Directed bench for alu_logic_arbiter: reset, tie arbitration, single ops, backpressure, mid-operation reset.
module tb_alu_logic_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [3:0] rsp_data;
    logic       busy;

    int total = 0;
    int bad   = 0;

    alu_logic_arbiter #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Inputs driven at posedge+1, combinational ready sampled 1ns later.
    task automatic settle;
        #1;
    endtask

    // One command from a single requester with rsp ready held high.
    task automatic single(input logic id, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] exp, input string tag);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        settle();
        chk({tag, " accept ready0"}, {7'd0, req0_ready}, {7'd0, ~id});
        chk({tag, " accept ready1"}, {7'd0, req1_ready}, {7'd0, id});
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, " exec busy"}, {7'd0, busy}, 8'd1);
        chk({tag, " exec no rsp"}, {6'd0, rsp1_valid, rsp0_valid}, 8'd0);
        tick();
        chk({tag, " rsp valids"}, {6'd0, rsp1_valid, rsp0_valid}, id ? 8'd2 : 8'd1);
        chk({tag, " rsp data"}, {4'd0, rsp_data}, {4'd0, exp});
        tick();
        chk({tag, " idle busy"}, {7'd0, busy}, 8'd0);
    endtask

    logic exp_win [4];

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'h0; req0_b = 4'h0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = 4'h0; req1_b = 4'h0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick();
        tick();
        chk("reset busy", {7'd0, busy}, 8'd0);
        chk("reset rsp valids", {6'd0, rsp1_valid, rsp0_valid}, 8'd0);
        chk("reset rsp_data", {4'd0, rsp_data}, 8'd0);
        chk("reset ready masked", {6'd0, req1_ready, req0_ready}, 8'd0);
        rst_n = 1'b1;
        req0_valid = 1'b0;
        tick();

        // Tie with both valid continuously.
`ifdef ALU_ARB_RR_EN
        exp_win[0] = 1'b0; exp_win[1] = 1'b1; exp_win[2] = 1'b0; exp_win[3] = 1'b1;
`else
        exp_win[0] = 1'b0; exp_win[1] = 1'b0; exp_win[2] = 1'b0; exp_win[3] = 1'b0;
`endif
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'b1010; req0_b = 4'b0101;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 4'b1100; req1_b = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("tie%0d ready", i), {6'd0, req1_ready, req0_ready},
                exp_win[i] ? 8'd2 : 8'd1);
            tick();
            chk($sformatf("tie%0d exec ready", i), {6'd0, req1_ready, req0_ready}, 8'd0);
            tick();
            chk($sformatf("tie%0d rsp ready", i), {6'd0, req1_ready, req0_ready}, 8'd0);
            chk($sformatf("tie%0d rsp valids", i), {6'd0, rsp1_valid, rsp0_valid},
                exp_win[i] ? 8'd2 : 8'd1);
            chk($sformatf("tie%0d rsp data", i), {4'd0, rsp_data},
                exp_win[i] ? 8'b1000 : 8'b1111);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        single(1'b0, 2'b00, 4'b1010, 4'b0101, 4'b1111, "op0 OR");
        single(1'b1, 2'b00, 4'b1100, 4'b1010, 4'b1110, "op1 OR");
        single(1'b1, 2'b01, 4'b1100, 4'b1010, 4'b1000, "op1 AND");
        single(1'b1, 2'b10, 4'b1100, 4'b1010, 4'b0110, "op1 XOR");
        single(1'b1, 2'b11, 4'b1100, 4'b1010, 4'b0001, "op1 NOR");

        // Backpressure on requester 0 while requester 1 waits.
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 4'b1111; req0_b = 4'b0011;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 4'b1100; req1_b = 4'b1010;
        settle();
        chk("bp accept", {6'd0, req1_ready, req0_ready}, 8'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d rsp0_valid", i), {6'd0, rsp1_valid, rsp0_valid}, 8'd1);
            chk($sformatf("bp%0d rsp_data", i), {4'd0, rsp_data}, 8'b0011);
            chk($sformatf("bp%0d req1_ready", i), {7'd0, req1_ready}, 8'd0);
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        settle();
        chk("bp release req1_ready", {6'd0, req1_ready, req0_ready}, 8'd2);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("bp req1 rsp", {6'd0, rsp1_valid, rsp0_valid}, 8'd2);
        chk("bp req1 data", {4'd0, rsp_data}, 8'b0110);
        tick();

        // Reset while the command is in EXEC.
        req0_valid = 1'b1; req0_op = 2'b11; req0_a = 4'b0000; req0_b = 4'b0000;
        settle();
        chk("mid accept", {7'd0, req0_ready}, 8'd1);
        tick();
        chk("mid exec busy", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        tick();
        chk("mid reset busy", {7'd0, busy}, 8'd0);
        chk("mid reset rsp valids", {6'd0, rsp1_valid, rsp0_valid}, 8'd0);
        chk("mid reset rsp_data", {4'd0, rsp_data}, 8'd0);
        chk("mid reset ready masked", {7'd0, req0_ready}, 8'd0);
        rst_n = 1'b1;
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mid dropped%0d", i), {5'd0, busy, rsp1_valid, rsp0_valid}, 8'd0);
        end
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 4'b1111; req0_b = 4'b0101;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 4'b0001; req1_b = 4'b0010;
        settle();
        chk("post reset tie", {6'd0, req1_ready, req0_ready}, 8'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("post reset rsp", {6'd0, rsp1_valid, rsp0_valid}, 8'd1);
        chk("post reset data", {4'd0, rsp_data}, 8'b1010);
        tick();
        chk("post reset idle", {7'd0, busy}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_logic_arbiter.md
# alu_logic_arbiter

Shares one registered bitwise logic unit (OR/AND/XOR/NOR) between two requesters, for example the control FSM and the test/debug port. A valid/ready request handshake feeds a three-state sequencer, and results return on a held response handshake. The block sits in front of the ALU's logic slice and is the only path by which requesters reach it.

## Interface
Parameters
- WIDTH, 4, operand and result width in bits.

Ports
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid, req1_valid  in  1  requester 0/1 has a command pending.
- req0_op, req1_op  in  2  operation: 00 OR, 01 AND, 10 XOR, 11 NOR.
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands.
- req0_ready, req1_ready  out  1  command accepted this cycle (combinational grant).
- rsp0_valid, rsp1_valid  out  1  result available for requester 0/1.
- rsp0_ready, rsp1_ready  in  1  requester consumes the result.
- rsp_data  out  WIDTH  result; valid only while a rspX_valid is high.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any reqX_valid, arbitrate.
  - Assert the winner's reqX_ready for exactly that cycle.
  - Latch op/a/b and the winner id.
  - Go to EXEC.
- EXEC: compute op on the latched operands and register it into rsp_data. Go to RESP.
- RESP: hold rspX_valid for the latched id and hold rsp_data constant. On rspX_ready, go to IDLE.
- Arbitration uses a one-bit last_grant pointer.
  - If only one request is valid, that requester wins.
  - If both are valid, the requester that is not last_grant wins.
  - last_grant updates only on accept.
- reqX_ready is never high outside IDLE, and never high for both requesters at once.
- Requests that arrive while busy stay pending; the requester holds valid and operands stable until ready.
- Results are exactly WIDTH bits. NOR is the bitwise complement of OR within WIDTH. No carries, no flags.
- Reset (rst_n low at a clock edge), including mid-operation:
  - State becomes IDLE; busy, rsp0_valid, rsp1_valid and rsp_data become 0.
  - last_grant becomes 1, so requester 0 wins the first tie.
  - Any in-flight command is dropped without a response.
  - reqX_ready is forced 0 while rst_n is low.

## Timing
- Accept in cycle N, then EXEC in N+1, then rspX_valid high from N+2.
- Minimum latency from accept to response is 2 cycles.
- If rspX_ready is high in N+2, the block is in IDLE at N+3 and can accept in N+3. Peak throughput is one command per 3 cycles.
- Response backpressure: RESP holds indefinitely, and rsp_data is stable throughout.
- A requester may assert reqX_valid in the same cycle its response handshake completes. That request is arbitrated in the following IDLE cycle.
- rspX_ready is ignored unless the matching rspX_valid is high.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration with last_grant, as described above.
- ALU_ARB_RR_EN undefined: fixed priority, where requester 0 always wins ties.
  - last_grant is not implemented.
  - Requester 1 can starve while req0_valid stays high.
- All other behaviour and timing are identical in both configurations.

## Test plan
- Single op:
  - Stimulus: req0 OR with a=4'b1010, b=4'b0101, rsp0_ready held high.
  - Response: req0_ready in cycle N; rsp0_valid in N+2 with rsp_data=4'b1111; busy low in N+3.
- All ops, requester 1 only:
  - Stimulus: a=4'b1100, b=4'b1010.
  - Response: OR=1110, AND=1000, XOR=0110, NOR=0001; rsp1_valid only, never rsp0_valid.
- Tie after reset, with ALU_ARB_RR_EN:
  - Stimulus: both valid continuously.
  - Response: grants alternate 0,1,0,1; each ready pulse is a single cycle and never simultaneous.
- Tie without the macro:
  - Stimulus: both valid for 4 commands.
  - Response: all 4 grants go to requester 0; req1_ready stays 0.
- Backpressure:
  - Stimulus: rsp0_ready low for 5 cycles after rsp0_valid rises.
  - Response: rsp0_valid and rsp_data stable for all 5 cycles; req1_ready stays 0 until the handshake completes.
- Reset mid-operation:
  - Stimulus: rst_n low in EXEC.
  - Response: next cycle busy=0, rsp0_valid=0, rsp1_valid=0, rsp_data=0; no response for the dropped command; the next tie is won by requester 0.
